sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
- Conditioning stage between the board slide switches and the 8-bit switch PIO input port (in_port) of the Avalon-MM system.
- Synchronizes each raw asynchronous switch bit to clk, debounces it with a per-bit consecutive-stable counter, and drives a clean level for software to read.
- Also produces per-bit rise/fall pulses and a sticky rising-edge capture register. A future edge-interrupt PIO or hardware logic can use these without software polling.

Parameters:
- WIDTH, 8, number of switch bits
- SYNC_STAGES, 2, synchronizer flop depth (legal values >= 2)
- CNT_MAX, 50000, consecutive cycles a synchronized bit must differ from its stable value before the stable value flips (1 ms at 50 MHz; legal values >= 2)

Ports:
- clk  input  1  system clock, 50 MHz
- reset_n  input  1  reset, asynchronous, active-low
- sw_raw  input  WIDTH  raw switch pins, asynchronous to clk
- clear_edges  input  WIDTH  write-one-to-clear mask for edge_capture, sampled every cycle
- sw_stable  output  WIDTH  debounced level; drives the switch PIO in_port
- rise_pulse  output  WIDTH  1-cycle pulse when sw_stable[i] goes 0->1
- fall_pulse  output  WIDTH  1-cycle pulse when sw_stable[i] goes 1->0
- edge_capture  output  WIDTH  sticky rising-edge flags
- any_change  output  1  OR of rise_pulse and fall_pulse, same cycle

Behaviour:
- Reset is asynchronous, active-low. While reset_n=0 and on exit, all of the following are 0: synchronizer flops, counters, sw_stable, rise_pulse, fall_pulse, edge_capture, any_change.
- Synchronizer:
  - Per bit, a SYNC_STAGES-deep flop chain.
  - sync[i] is the last stage.
  - No logic sits between the stages.
- Debounce, per bit i, with counter cnt[i] of width clog2(CNT_MAX). Each rising edge does exactly one of:
  - sync[i]==sw_stable[i]: cnt[i]<=0.
  - Else, cnt[i]==CNT_MAX-1: sw_stable[i]<=sync[i], cnt[i]<=0, and the matching rise/fall pulse is asserted for exactly that next cycle.
  - Else: cnt[i]<=cnt[i]+1.
- Pulses and any_change are registered. They are high in the same cycle that sw_stable shows the new value.
- Latency: number the first clk edge that samples a new, steady sw_raw value as edge 1. sw_stable updates at edge SYNC_STAGES+CNT_MAX. Example: 2+4 gives edge 6.
- Glitch rejection:
  - Any disagreement run shorter than CNT_MAX cycles leaves sw_stable unchanged.
  - The counter returns to 0 on the first agreeing cycle. There is no partial credit.
- The counter never wraps: it is cleared at CNT_MAX-1 or on agreement.
- Bits are fully independent. Simultaneous flips on several bits give simultaneous pulses, and any_change is a single-cycle 1.
- edge_capture[i] is updated every cycle:
  - next value = (edge_capture[i] & ~clear_edges[i]) | rise_pulse[i]
  - When set and clear happen in the same cycle, set wins.
- Post-reset:
  - A switch held high through reset appears as 0, then rises at edge SYNC_STAGES+CNT_MAX after release, with a rise_pulse. This is intended.
  - Reset asserted mid-count discards the count.
- Outputs are pure flop outputs. There is no combinational path from sw_raw or clear_edges to any output.

Decomposition:
- Package sw_debounce_pkg holds:
  - default constants SW_WIDTH=8, SW_SYNC_STAGES=2, SW_CNT_MAX_1MS=50000
  - SIM_CNT_MAX=4, used by benches
  - a clog2 helper function
- Sub-module debounce_bit (single-bit synchronizer + counter + stable + rise/fall pulse). The top instantiates it WIDTH times with a generate loop and adds edge_capture and any_change.

Test Plan (CNT_MAX=4, SYNC_STAGES=2, WIDTH=8):
- Reset with sw_raw=8'h00, release, hold 20 cycles -> all outputs 0 throughout, no pulses.
- sw_raw 8'h00->8'h05 sampled at edge 1 -> sw_stable=8'h05 after edge 6, rise_pulse=8'h05 and any_change=1 for exactly that cycle, edge_capture=8'h05.
- Bit 3 glitch high for 3 cycles, then low -> sw_stable[3] stays 0, no pulse; the counter is back at 0. A following 4-cycle-high run (after sync) does flip it.
- From 8'h05, sw_raw->8'h04 -> fall_pulse=8'h01 at edge 6, edge_capture unchanged (8'h05).
- clear_edges=8'h01 in the same cycle as a new rise_pulse[0] -> edge_capture[0] stays 1. clear_edges=8'h04 alone -> edge_capture[2] is 0 next cycle.
- Assert reset_n mid-count (cnt=2 on bit 7) -> immediate zeroing. After release with sw_raw[7]=1, the rise appears at edge 6, not earlier.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the slide-switch conditioning stage.
package sw_debounce_pkg;

   localparam int SW_WIDTH       = 8;
   localparam int SW_SYNC_STAGES = 2;
   localparam int SW_CNT_MAX_1MS = 50000;
   localparam int SIM_CNT_MAX    = 4;

   // Ceiling log2, never less than 1 so a counter always has at least one bit.
   function automatic int clog2(input int value);
      int bits;
      bits = 1;
      for (int i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            bits = i + 1;
         end else begin
            bits = bits;
         end
      end
      return bits;
   endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch-side bundle: raw pins and edge-clear mask in, conditioned levels and pulses out.
interface sw_debounce_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] clear_edges;
   logic [WIDTH-1:0] sw_stable;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;
   logic [WIDTH-1:0] edge_capture;
   logic             any_change;

   modport master (
      output sw_raw,
      output clear_edges,
      input  sw_stable,
      input  rise_pulse,
      input  fall_pulse,
      input  edge_capture,
      input  any_change
   );

   modport slave (
      input  sw_raw,
      input  clear_edges,
      output sw_stable,
      output rise_pulse,
      output fall_pulse,
      output edge_capture,
      output any_change
   );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchronizer chain, consecutive-disagreement counter, stable level and
// registered rise/fall pulses. flip_next lets the parent register a same-cycle summary.
module debounce_bit
   import sw_debounce_pkg::*;
#(
   parameter int SYNC_STAGES = SW_SYNC_STAGES,
   parameter int CNT_MAX     = SW_CNT_MAX_1MS
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall,
   output logic flip_next
);

   localparam int              CW       = clog2(CNT_MAX);
   localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_MAX - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_s;
   logic [CW-1:0]          cnt_r;
   logic [CW-1:0]          cnt_nxt_s;
   logic                   stable_r;
   logic                   stable_nxt_s;
   logic                   rise_r;
   logic                   fall_r;
   logic                   rise_nxt_s;
   logic                   fall_nxt_s;

   assign sync_s = sync_r[SYNC_STAGES-1];

   // Synchronizer flop chain, plain shift with nothing between stages.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
      end
   end

   // State register: counter, stable level and the pulses that accompany a flip.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r    <= {CW{1'b0}};
         stable_r <= 1'b0;
         rise_r   <= 1'b0;
         fall_r   <= 1'b0;
      end else begin
         cnt_r    <= cnt_nxt_s;
         stable_r <= stable_nxt_s;
         rise_r   <= rise_nxt_s;
         fall_r   <= fall_nxt_s;
      end
   end

   // Next state: any agreeing cycle forfeits the whole run; the counter never wraps.
   always_comb begin
      cnt_nxt_s    = cnt_r;
      stable_nxt_s = stable_r;
      rise_nxt_s   = 1'b0;
      fall_nxt_s   = 1'b0;
      if (sync_s == stable_r) begin
         cnt_nxt_s = {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
         cnt_nxt_s    = {CW{1'b0}};
         stable_nxt_s = sync_s;
         rise_nxt_s   = sync_s;
         fall_nxt_s   = ~sync_s;
      end else begin
         cnt_nxt_s = cnt_r + CW'(1);
      end
   end

   // Outputs are taken straight from flops.
   always_comb begin
      stable    = stable_r;
      rise      = rise_r;
      fall      = fall_r;
      flip_next = rise_nxt_s | fall_nxt_s;
   end

endmodule

// File: rtl/sw_debounce.sv
// Debounced switch PIO front end: WIDTH independent debounce_bit slices plus a sticky
// rising-edge capture register and a registered any-change flag.
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int WIDTH       = SW_WIDTH,
   parameter int SYNC_STAGES = SW_SYNC_STAGES,
   parameter int CNT_MAX     = SW_CNT_MAX_1MS
) (
   input  logic          clk,
   input  logic          reset_n,
   sw_debounce_if.slave  bus
);

   logic [WIDTH-1:0] stable_s;
   logic [WIDTH-1:0] rise_s;
   logic [WIDTH-1:0] fall_s;
   logic [WIDTH-1:0] flip_s;
   logic [WIDTH-1:0] edge_capture_r;
   logic             any_change_r;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      debounce_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_MAX     (CNT_MAX)
      ) u_bit (
         .clk       (clk),
         .reset_n   (reset_n),
         .raw       (bus.sw_raw[g]),
         .stable    (stable_s[g]),
         .rise      (rise_s[g]),
         .fall      (fall_s[g]),
         .flip_next (flip_s[g])
      );
   end

   // Sticky capture (a set in the same cycle as a clear wins) and the change summary,
   // registered so it lines up with the pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_capture_r <= {WIDTH{1'b0}};
         any_change_r   <= 1'b0;
      end else begin
         edge_capture_r <= (edge_capture_r & ~bus.clear_edges) | rise_s;
         any_change_r   <= |flip_s;
      end
   end

   // Drive the bundle from registered state only.
   always_comb begin
      bus.sw_stable    = stable_s;
      bus.rise_pulse   = rise_s;
      bus.fall_pulse   = fall_s;
      bus.edge_capture = edge_capture_r;
      bus.any_change   = any_change_r;
   end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed scenarios plus randomized toggling, each compared with a
// window-based model (a bit flips once its last CNT_MAX synchronized samples all disagree).
module tb_sw_debounce;
   import sw_debounce_pkg::*;

   localparam int W  = 8;
   localparam int SS = 2;
   localparam int CM = SIM_CNT_MAX;

   logic         clk;
   logic         reset_n;
   logic [W-1:0] raw_d;
   logic [W-1:0] clear_d;

   int n_tests;
   int n_fail;

   sw_debounce_if #(.WIDTH(W)) bus ();

   assign bus.sw_raw      = raw_d;
   assign bus.clear_edges = clear_d;

   sw_debounce #(
      .WIDTH       (W),
      .SYNC_STAGES (SS),
      .CNT_MAX     (CM)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state.
   logic [W-1:0] m_pipe[$];
   logic [W-1:0] m_win[$];
   logic [W-1:0] m_stable, m_rise, m_fall, m_ec;
   logic         m_any;

   function automatic void model_reset();
      m_pipe.delete();
      m_win.delete();
      for (int i = 0; i < SS; i++) m_pipe.push_back('0);
      for (int i = 0; i < CM; i++) m_win.push_back('0);
      m_stable = '0; m_rise = '0; m_fall = '0; m_ec = '0; m_any = 1'b0;
   endfunction

   function automatic void model_step(input logic [W-1:0] raw, input logic [W-1:0] clr);
      logic [W-1:0] obs, r, f, new_ec;
      logic all_diff;
      obs = m_pipe.pop_front();
      m_pipe.push_back(raw);
      m_win.push_back(obs);
      if (m_win.size() > CM) void'(m_win.pop_front());
      new_ec = (m_ec & ~clr) | m_rise;
      r = '0; f = '0;
      for (int i = 0; i < W; i++) begin
         all_diff = 1'b1;
         foreach (m_win[j]) if (m_win[j][i] == m_stable[i]) all_diff = 1'b0;
         if (all_diff) begin
            if (m_stable[i]) f[i] = 1'b1; else r[i] = 1'b1;
         end
      end
      m_stable = m_stable ^ (r | f);
      m_rise = r; m_fall = f; m_any = |(r | f); m_ec = new_ec;
   endfunction

   task automatic step();
      @(posedge clk);
      if (reset_n) model_step(raw_d, clear_d);
      else model_reset();
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; raw_d = 8'h00; clear_d = 8'h00;
      model_reset();
      #1;
      n_tests++;
      if ({bus.sw_stable, bus.rise_pulse, bus.fall_pulse, bus.edge_capture, bus.any_change} !== 33'd0) begin
         n_fail++;
         $display("FAIL reset_hold act=%h exp=0", {bus.sw_stable, bus.rise_pulse, bus.fall_pulse, bus.edge_capture, bus.any_change});
      end
      repeat (3) step();
      @(negedge clk) reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         n_tests++;
         if ({bus.sw_stable, bus.rise_pulse, bus.fall_pulse, bus.edge_capture, bus.any_change} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_idle cyc=%0d act=%h exp=0", c, {bus.sw_stable, bus.rise_pulse, bus.fall_pulse, bus.edge_capture, bus.any_change});
         end
      end
   endtask

   task automatic test_rise();
      raw_d = 8'h05;
      for (int e = 1; e <= 5; e++) begin
         step();
         n_tests++;
         if (bus.sw_stable !== 8'h00 || bus.any_change !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_early edge=%0d stable=%h any=%b exp 00/0", e, bus.sw_stable, bus.any_change);
         end
      end
      step();
      n_tests++;
      if (bus.sw_stable !== 8'h05 || bus.rise_pulse !== 8'h05 || bus.any_change !== 1'b1 || bus.fall_pulse !== 8'h00) begin
         n_fail++;
         $display("FAIL rise_edge6 stable=%h rise=%h fall=%h any=%b exp 05/05/00/1", bus.sw_stable, bus.rise_pulse, bus.fall_pulse, bus.any_change);
      end
      step();
      n_tests++;
      if (bus.rise_pulse !== 8'h00 || bus.any_change !== 1'b0 || bus.edge_capture !== 8'h05) begin
         n_fail++;
         $display("FAIL rise_after rise=%h any=%b ec=%h exp 00/0/05", bus.rise_pulse, bus.any_change, bus.edge_capture);
      end
   endtask

   task automatic test_fall();
      raw_d = 8'h04;
      for (int e = 1; e <= 5; e++) step();
      n_tests++;
      if (bus.sw_stable !== 8'h05 || bus.fall_pulse !== 8'h00) begin
         n_fail++;
         $display("FAIL fall_early stable=%h fall=%h exp 05/00", bus.sw_stable, bus.fall_pulse);
      end
      step();
      n_tests++;
      if (bus.sw_stable !== 8'h04 || bus.fall_pulse !== 8'h01 || bus.any_change !== 1'b1 || bus.edge_capture !== 8'h05) begin
         n_fail++;
         $display("FAIL fall_edge6 stable=%h fall=%h any=%b ec=%h exp 04/01/1/05", bus.sw_stable, bus.fall_pulse, bus.any_change, bus.edge_capture);
      end
      step();
   endtask

   task automatic test_glitch();
      int rises;
      raw_d = 8'h0C;
      repeat (3) step();
      raw_d = 8'h04;
      for (int c = 0; c < 10; c++) begin
         step();
         n_tests++;
         if (bus.sw_stable !== 8'h04 || bus.rise_pulse !== 8'h00 || bus.fall_pulse !== 8'h00) begin
            n_fail++;
            $display("FAIL glitch_reject cyc=%0d stable=%h rise=%h fall=%h exp 04/00/00", c, bus.sw_stable, bus.rise_pulse, bus.fall_pulse);
         end
      end
      rises = 0;
      raw_d = 8'h0C;
      for (int c = 0; c < 12; c++) begin
         if (c == 4) raw_d = 8'h04;
         step();
         if (bus.rise_pulse[3]) rises++;
         n_tests++;
         if ({bus.sw_stable, bus.rise_pulse, bus.fall_pulse, bus.edge_capture, bus.any_change} !== {m_stable, m_rise, m_fall, m_ec, m_any}) begin
            n_fail++;
            $display("FAIL glitch_run cyc=%0d act=%h exp=%h", c, {bus.sw_stable, bus.rise_pulse, bus.fall_pulse, bus.edge_capture, bus.any_change}, {m_stable, m_rise, m_fall, m_ec, m_any});
         end
      end
      n_tests++;
      if (rises != 1) begin
         n_fail++;
         $display("FAIL glitch_flip rise3_count=%0d exp=1", rises);
      end
      clear_d = 8'h08;
      step();
      clear_d = 8'h00;
      n_tests++;
      if (bus.edge_capture !== 8'h05 || bus.sw_stable !== 8'h04) begin
         n_fail++;
         $display("FAIL glitch_clear ec=%h stable=%h exp 05/04", bus.edge_capture, bus.sw_stable);
      end
   endtask

   task automatic test_clear();
      clear_d = 8'h01;
      step();
      clear_d = 8'h00;
      n_tests++;
      if (bus.edge_capture !== 8'h04) begin
         n_fail++;
         $display("FAIL clear_plain ec=%h exp=04", bus.edge_capture);
      end
      raw_d = 8'h05;
      repeat (6) step();
      n_tests++;
      if (bus.rise_pulse !== 8'h01 || bus.edge_capture !== 8'h04) begin
         n_fail++;
         $display("FAIL clear_rise rise=%h ec=%h exp 01/04", bus.rise_pulse, bus.edge_capture);
      end
      clear_d = 8'h01;
      step();
      n_tests++;
      if (bus.edge_capture !== 8'h05) begin
         n_fail++;
         $display("FAIL clear_set_wins ec=%h exp=05", bus.edge_capture);
      end
      clear_d = 8'h04;
      step();
      clear_d = 8'h00;
      n_tests++;
      if (bus.edge_capture !== 8'h01) begin
         n_fail++;
         $display("FAIL clear_bit2 ec=%h exp=01", bus.edge_capture);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] flips;
      for (int c = 0; c < 1500; c++) begin
         flips = '0;
         for (int i = 0; i < W; i++) flips[i] = ($urandom_range(0, 5) == 0);
         raw_d = raw_d ^ flips;
         clear_d = ($urandom_range(0, 3) == 0) ? W'($urandom) : 8'h00;
         step();
         n_tests++;
         if ({bus.sw_stable, bus.rise_pulse, bus.fall_pulse, bus.edge_capture, bus.any_change} !== {m_stable, m_rise, m_fall, m_ec, m_any}) begin
            n_fail++;
            $display("FAIL random cyc=%0d act=%h exp=%h", c, {bus.sw_stable, bus.rise_pulse, bus.fall_pulse, bus.edge_capture, bus.any_change}, {m_stable, m_rise, m_fall, m_ec, m_any});
         end
      end
      clear_d = 8'h00;
   endtask

   task automatic test_reset_midcount();
      raw_d = 8'h00;
      repeat (12) step();
      raw_d = 8'h80;
      repeat (4) step();
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if ({bus.sw_stable, bus.rise_pulse, bus.fall_pulse, bus.edge_capture, bus.any_change} !== 33'd0) begin
         n_fail++;
         $display("FAIL midcount_zero act=%h exp=0", {bus.sw_stable, bus.rise_pulse, bus.fall_pulse, bus.edge_capture, bus.any_change});
      end
      repeat (3) step();
      @(negedge clk) reset_n = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         step();
         n_tests++;
         if (bus.sw_stable[7] !== 1'b0 || bus.rise_pulse[7] !== 1'b0) begin
            n_fail++;
            $display("FAIL midcount_early edge=%0d stable=%h rise=%h exp bit7 0", e, bus.sw_stable, bus.rise_pulse);
         end
      end
      step();
      n_tests++;
      if (bus.sw_stable !== 8'h80 || bus.rise_pulse !== 8'h80 || bus.any_change !== 1'b1) begin
         n_fail++;
         $display("FAIL midcount_edge6 stable=%h rise=%h any=%b exp 80/80/1", bus.sw_stable, bus.rise_pulse, bus.any_change);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_rise();
      test_fall();
      test_glitch();
      test_clear();
      test_random();
      test_reset_midcount();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
